// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans one digit per slot, decodes hex nibbles, supports decimal points,
// per-digit blanking and leading-zero blanking, and double-buffers the
// displayed data so a new value only appears at a frame boundary.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int DIV         = 50,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_blank_en,
    input  logic                  update,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYCLES);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap_tick;
    logic                  pending;
    logic [4*N_DIGITS-1:0] shadow_value;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_blank;

    logic [N_DIGITS-1:0]   lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    // Active-low hex decode, bit0 = segment a ... bit6 = segment g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign tick      = (presc == PRESC_MAX);
    assign wrap_tick = tick && (idx == IDX_MAX);

    // Slot prescaler and digit index; wrap_tick marks the last clock of a frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Double buffer: an update request is held until the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
        end else if (wrap_tick && (pending || update)) begin
            pending      <= 1'b0;
            shadow_value <= value;
            shadow_dp    <= dp_in;
            shadow_blank <= blank_in;
        end else if (update) begin
            pending      <= 1'b1;
        end
    end

    // Leading-zero mask: digit i>0 is dark when it and every digit above it are zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (shadow_value[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    // Next output values for the digit selected by the current index.
    always_comb begin
        cur_nib   = shadow_value[4*idx +: 4];
        cur_blank = shadow_blank[idx] | (lz_blank_en & lz_mask[idx]);
        seg_next  = 7'h7F;
        dp_next   = 1'b1;
        an_next   = '1;
        if (!cur_blank) begin
            seg_next = hex_to_seg(cur_nib);
            dp_next  = ~shadow_dp[idx];
        end
        // Anodes stay off at the start of a slot so the previous digit's
        // segments cannot ghost onto the newly selected digit.
        if (presc >= DEAD_END) begin
            an_next[idx] = 1'b0;
        end
    end

    // Registered pin outputs and the frame wrap pulse.
    always_ff @(posedge clk) begin
        // NOTE: the output pins are reset explicitly so the display is dark
        // from the first clock; the shadow buffer above is reset because the
        // display must restart from a known all-zero value.
        if (rst) begin
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            dp_n       <= dp_next;
            an_n       <= an_next;
            frame_done <= wrap_tick;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver with N_DIGITS=4, DIV=4, DEAD_CYCLES=1.
// Frames are recorded sample by sample on the falling edge and compared
// against hand-derived expectations.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_blank_en;
    logic        update;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int compared   = 0;
    int mismatched = 0;

    // Active-low hex codes, index = nibble.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // One recorded frame: sample j taken j+1 falling edges after frame_done.
    logic [6:0] g_seg [16];
    logic       g_dp  [16];
    logic [3:0] g_an  [16];
    logic       g_fd  [16];

    seg7_scan_driver #(
        .N_DIGITS   (4),
        .DIV        (4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_blank_en(lz_blank_en),
        .update     (update),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        compared++;
        if (frame_done !== 1'b1) begin
            mismatched++;
            $display("FAIL wait_frame_done: frame_done=%b after %0d clks, required 1", frame_done, n);
        end
    endtask

    task automatic grab_frame();
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            g_seg[j] = seg_n;
            g_dp[j]  = dp_n;
            g_an[j]  = an_n;
            g_fd[j]  = frame_done;
        end
    endtask

    task automatic test_reset();
        logic [3:0] first_an;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared += 4;
            if (seg_n !== 7'h7F) begin
                mismatched++;
                $display("FAIL reset_seg clk%0d: got %h, required 7f", c, seg_n);
            end
            if (an_n !== 4'hF) begin
                mismatched++;
                $display("FAIL reset_an clk%0d: got %h, required f", c, an_n);
            end
            if (dp_n !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_dp clk%0d: got %b, required 1", c, dp_n);
            end
            if (frame_done !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_fd clk%0d: got %b, required 0", c, frame_done);
            end
        end
        rst = 1'b0;
        first_an = 4'hF;
        for (int c = 0; c < 20 && first_an === 4'hF; c++) begin
            @(negedge clk);
            first_an = an_n;
        end
        compared++;
        if (first_an !== 4'b1110) begin
            mismatched++;
            $display("FAIL reset_first_anode: got %b, required 1110", first_an);
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] v;
        v = 16'h00A5;
        value = v;
        dp_in = 4'b0000;
        blank_in = 4'b0000;
        lz_blank_en = 1'b1;
        pulse_update();
        wait_frame_done();
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            logic [6:0] exp_seg;
            exp_seg = (d < 2) ? seg_tab[v[4*d +: 4]] : 7'h7F;
            compared += 2;
            if (g_seg[4*d+2] !== exp_seg) begin
                mismatched++;
                $display("FAIL lz_seg digit%0d: got %h, required %h", d, g_seg[4*d+2], exp_seg);
            end
            if (g_an[4*d+2] !== ~(4'b0001 << d)) begin
                mismatched++;
                $display("FAIL lz_anode digit%0d: got %b, required %b", d, g_an[4*d+2], ~(4'b0001 << d));
            end
        end
    endtask

    task automatic test_zero();
        value = 16'h0000;
        lz_blank_en = 1'b1;
        pulse_update();
        wait_frame_done();
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            logic [6:0] exp_seg;
            exp_seg = (d == 0) ? 7'h40 : 7'h7F;
            compared++;
            if (g_seg[4*d+2] !== exp_seg) begin
                mismatched++;
                $display("FAIL zero_lz digit%0d: got %h, required %h", d, g_seg[4*d+2], exp_seg);
            end
        end
        lz_blank_en = 1'b0;
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (g_seg[4*d+2] !== 7'h40) begin
                mismatched++;
                $display("FAIL zero_nolz digit%0d: got %h, required 40", d, g_seg[4*d+2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        // Aligned on a frame_done edge (m=0); shadow currently holds 0.
        repeat (2) @(negedge clk);
        value = 16'h1234;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (2) @(negedge clk);
        v = 16'h5678;
        value = v;
        @(negedge clk);
        compared += 2;
        if (seg_n !== 7'h40) begin
            mismatched++;
            $display("FAIL tear_old_digit1: got %h, required 40", seg_n);
        end
        if (an_n !== 4'b1101) begin
            mismatched++;
            $display("FAIL tear_old_anode: got %b, required 1101", an_n);
        end
        repeat (10) @(negedge clk);
        compared++;
        if (frame_done !== 1'b1) begin
            mismatched++;
            $display("FAIL tear_wrap_fd: got %b, required 1", frame_done);
        end
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (g_seg[4*d+2] !== seg_tab[v[4*d +: 4]]) begin
                mismatched++;
                $display("FAIL tear_new digit%0d: got %h, required %h", d, g_seg[4*d+2], seg_tab[v[4*d +: 4]]);
            end
        end
        // Update asserted in the wrap-tick cycle itself (m=15).
        repeat (15) @(negedge clk);
        v = 16'h9ABC;
        value = v;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        value = 16'hFFFF;
        compared++;
        if (frame_done !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_update_fd: got %b, required 1", frame_done);
        end
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (g_seg[4*d+2] !== seg_tab[v[4*d +: 4]]) begin
                mismatched++;
                $display("FAIL wrap_update digit%0d: got %h, required %h", d, g_seg[4*d+2], seg_tab[v[4*d +: 4]]);
            end
        end
    endtask

    task automatic test_scan_timing();
        value = 16'h8888;
        dp_in = 4'b0110;
        blank_in = 4'b0100;
        lz_blank_en = 1'b0;
        pulse_update();
        wait_frame_done();
        grab_frame();
        for (int j = 0; j < 16; j++) begin
            int d;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dp;
            d = j / 4;
            exp_an  = (j % 4 == 0) ? 4'hF : ~(4'b0001 << d);
            exp_seg = (d == 2) ? 7'h7F : 7'h00;
            exp_dp  = (d == 1) ? 1'b0 : 1'b1;
            compared += 4;
            if (g_an[j] !== exp_an) begin
                mismatched++;
                $display("FAIL scan_anode s%0d: got %b, required %b", j, g_an[j], exp_an);
            end
            if (g_seg[j] !== exp_seg) begin
                mismatched++;
                $display("FAIL scan_seg s%0d: got %h, required %h", j, g_seg[j], exp_seg);
            end
            if (g_dp[j] !== exp_dp) begin
                mismatched++;
                $display("FAIL scan_dp s%0d: got %b, required %b", j, g_dp[j], exp_dp);
            end
            if (g_fd[j] !== (j == 15)) begin
                mismatched++;
                $display("FAIL scan_fd s%0d: got %b, required %b", j, g_fd[j], (j == 15));
            end
        end
        grab_frame();
        for (int j = 0; j < 16; j++) begin
            compared++;
            if (g_fd[j] !== (j == 15)) begin
                mismatched++;
                $display("FAIL fd_period s%0d: got %b, required %b", j, g_fd[j], (j == 15));
            end
        end
    endtask

    task automatic test_mid_reset();
        value = 16'h4321;
        dp_in = 4'b1111;
        blank_in = 4'b0000;
        lz_blank_en = 1'b1;
        repeat (10) @(negedge clk);
        compared++;
        if (an_n !== 4'b1011) begin
            mismatched++;
            $display("FAIL midrst_pre_anode: got %b, required 1011", an_n);
        end
        rst = 1'b1;
        @(negedge clk);
        compared += 4;
        if (seg_n !== 7'h7F) begin
            mismatched++;
            $display("FAIL midrst_seg: got %h, required 7f", seg_n);
        end
        if (dp_n !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_dp: got %b, required 1", dp_n);
        end
        if (an_n !== 4'hF) begin
            mismatched++;
            $display("FAIL midrst_anode: got %b, required 1111", an_n);
        end
        if (frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_fd: got %b, required 0", frame_done);
        end
        rst = 1'b0;
        @(negedge clk);
        compared += 3;
        if (an_n !== 4'hF) begin
            mismatched++;
            $display("FAIL restart_dead_anode: got %b, required 1111", an_n);
        end
        if (seg_n !== 7'h40) begin
            mismatched++;
            $display("FAIL restart_dead_seg: got %h, required 40", seg_n);
        end
        if (dp_n !== 1'b1) begin
            mismatched++;
            $display("FAIL restart_dp: got %b, required 1", dp_n);
        end
        @(negedge clk);
        compared += 2;
        if (an_n !== 4'b1110) begin
            mismatched++;
            $display("FAIL restart_anode: got %b, required 1110", an_n);
        end
        if (seg_n !== 7'h40) begin
            mismatched++;
            $display("FAIL restart_seg: got %h, required 40", seg_n);
        end
        repeat (4) @(negedge clk);
        compared += 2;
        if (an_n !== 4'b1101) begin
            mismatched++;
            $display("FAIL restart_digit1_anode: got %b, required 1101", an_n);
        end
        if (seg_n !== 7'h7F) begin
            mismatched++;
            $display("FAIL restart_digit1_seg: got %h, required 7f", seg_n);
        end
    endtask

    initial begin
        rst = 1'b1;
        value = 16'h0000;
        dp_in = 4'b0000;
        blank_in = 4'b0000;
        lz_blank_en = 1'b0;
        update = 1'b0;
        test_reset();
        test_lz_blank();
        test_zero();
        test_back_to_back();
        test_scan_timing();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
